aes_stream_fifo: RTL and testbench
==================================

Name: aes_stream_fifo

Overview:
- Parametrised successor to the fixed 32x131 AES input buffer.
- Sits between the host/key-schedule front end and the AES core.
- Single-clock FIFO, first-word-fall-through (FWFT), valid/ready on both sides.
- Adds: occupancy count, programmable almost-full, synchronous flush, high-water-mark tracking.

Parameters:
- WIDTH, 131, payload bits per entry (128 data + 3 tag bits by default); any value >= 1.
- DEPTH, 32, number of entries; must be a power of two, >= 2.
- AF_THRESH, 28, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rstn, input, 1, asynchronous reset, active-high (asserted = 1).
- flush, input, 1, synchronous flush; empties the FIFO.
- in_valid, input, 1, producer has an entry.
- in_ready, output, 1, FIFO can accept this cycle (= !full).
- in_data, input, WIDTH, write payload.
- out_valid, output, 1, head entry present (= !empty).
- out_ready, input, 1, consumer takes the head this cycle.
- out_data, output, WIDTH, head entry; forced to 0 when out_valid = 0.
- count, output, $clog2(DEPTH)+1, current occupancy, 0..DEPTH.
- almost_full, output, 1, registered; equals (count >= AF_THRESH).
- hwm, output, $clog2(DEPTH)+1, maximum count since reset/hwm_clr.
- hwm_clr, input, 1, synchronous clear of hwm to the current count.

Behaviour:
- Storage: DEPTH x WIDTH array, no reset on contents.
- Pointers: wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
- Reset (rstn = 1, async): wr_ptr = rd_ptr = 0, count = 0, hwm = 0, almost_full = 0. Hence in_ready = 1, out_valid = 0, out_data = 0.
- push = in_valid & in_ready. Writes mem[wr_ptr[low]] and increments wr_ptr.
- pop = out_valid & out_ready. Increments rd_ptr.
- FWFT: out_data = mem[rd_ptr[low]] combinationally while out_valid = 1.
  - An entry pushed in cycle N is visible at the output in cycle N+1; write-to-read latency is 1 cycle.
- Push and pop together (not full, not empty): both pointers advance, count unchanged.
- Full: in_ready = 0, so no push; a pop still proceeds. in_ready returns to 1 the cycle after the pop.
- Empty: out_valid = 0, so out_ready is ignored. A push while empty does not bypass to the output in the same cycle.
- Wrap-around: low pointer bits roll from DEPTH-1 to 0 and the wrap bit toggles. count = wr_ptr - rd_ptr (modulo 2^(ptr width)).
- count, almost_full and hwm are registered and reflect the state after the current edge.
- hwm: next_hwm = max(hwm, next_count). With hwm_clr, next_hwm = next_count.
- flush has priority over push and pop in the same cycle.
  - Both pointers are set to 0 and count to 0; any concurrent push is discarded.
  - Next cycle: out_valid = 0, in_ready = 1, almost_full = 0.
  - hwm is not changed by flush.
- A reset asserted mid-transfer aborts immediately; data held in the FIFO is lost, and the first pop after reset is the first push after reset.
- Producer is not required to hold in_valid while stalled; the FIFO never drops or duplicates an entry.

Test Plan:
- Reset, then push 0x1, 0x2, 0x3 with out_ready = 0 -> count = 3, out_data = 0x1; then pop 3 -> data 0x1, 0x2, 0x3 in order, out_valid = 0, out_data = 0.
- Push 32 entries (DEPTH = 32) -> in_ready = 0 after the 32nd, almost_full = 1 from count 28, count = 32. A 33rd in_valid is not accepted. Pop 1 -> in_ready = 1 next cycle.
- Steady push + pop every cycle for 100 cycles from count = 5 -> count stays 5, pointers wrap three times, output order preserved.
- Fill to 20, assert flush together with in_valid -> next cycle count = 0, out_valid = 0. The flushed-cycle push is absent; hwm = 20.
- hwm: fill to 12, drain to 4, pulse hwm_clr -> hwm = 4; push 2 -> hwm = 6.
- Assert rstn asynchronously mid-stream at count = 9 -> outputs reset before the next edge; count = 0, hwm = 0, in_ready = 1.

Source files
------------

// File: rtl/aes_stream_fifo.sv
// Single-clock FWFT FIFO feeding the AES core, with valid/ready on both sides.
// Also provides occupancy, a registered almost-full flag, synchronous flush and high-water-mark tracking.
module aes_stream_fifo #(
  parameter int WIDTH     = 131,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = 28
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   hwm,
  input  logic                     hwm_clr
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_count;
  logic [PTR_W-1:0] r_hwm;
  logic             r_almost_full;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [PTR_W-1:0] w_count_nxt;
  logic [PTR_W-1:0] w_hwm_nxt;

  // The pointer MSB is a wrap bit: equal low bits with differing wrap bits means full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                   (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
  assign w_push  = in_valid & ~w_full;
  assign w_pop   = out_ready & ~w_empty;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end else begin
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
    end
    w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
    if (hwm_clr)                  w_hwm_nxt = w_count_nxt;
    else if (w_count_nxt > r_hwm) w_hwm_nxt = w_count_nxt;
    else                          w_hwm_nxt = r_hwm;
  end

  always_ff @(posedge clk or posedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rstn) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_hwm         <= '0;
      r_almost_full <= 1'b0;
    end else begin
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_count       <= w_count_nxt;
      r_hwm         <= w_hwm_nxt;
      r_almost_full <= (w_count_nxt >= AF_LVL);
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr[ADDR_W-1:0]] <= in_data;
  end

  assign in_ready    = ~w_full;
  assign out_valid   = ~w_empty;
  assign out_data    = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign count       = r_count;
  assign almost_full = r_almost_full;
  assign hwm         = r_hwm;

endmodule

// File: tb/tb_aes_stream_fifo.sv
// Randomised bench for aes_stream_fifo: a queue-based reference model tracks contents,
// occupancy and high-water mark, and a negedge monitor compares every output against it.
module tb_aes_stream_fifo;

  localparam int WIDTH = 131;
  localparam int DEPTH = 32;
  localparam int AF    = 28;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             almost_full;
  logic [CW-1:0]    hwm;
  logic             hwm_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] m_q[$];
  int               m_hwm = 0;

  aes_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full), .hwm(hwm), .hwm_clr(hwm_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_data();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[WIDTH-1:0];
  endfunction

  // Reference model: a plain queue of accepted entries; occupancy is its size.
  always @(posedge clk or posedge rstn) begin
    if (rstn) begin
      m_q.delete();
      m_hwm = 0;
    end else begin
      if (flush) begin
        m_q.delete();
      end else begin
        logic do_pop, do_push;
        do_pop  = out_ready && (m_q.size() > 0);
        do_push = in_valid && (m_q.size() < DEPTH);
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back(in_data);
      end
      if (hwm_clr || m_q.size() > m_hwm) m_hwm = m_q.size();
    end
  end

  // Monitor: mid-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic [WIDTH-1:0] head;
    head = (m_q.size() > 0) ? m_q[0] : '0;
    check("count",       count,       m_q.size());
    check("in_ready",    in_ready,    m_q.size() < DEPTH);
    check("out_valid",   out_valid,   m_q.size() > 0);
    check("out_data",    out_data,    head);
    check("almost_full", almost_full, m_q.size() >= AF);
    check("hwm",         hwm,         m_hwm);
  end

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r,
                      input logic f, input logic h);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    hwm_clr   = h;
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) step(1'b1, rand_data(), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    #2 rstn = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  '0);
    check("rst_count",     count,     '0);
    rstn = 1'b0;
    @(posedge clk); #1;

    // Ordered push of 1,2,3 then drain.
    step(1'b1, WIDTH'(1), 1'b0, 1'b0, 1'b0);
    step(1'b1, WIDTH'(2), 1'b0, 1'b0, 1'b0);
    step(1'b1, WIDTH'(3), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("three_count", count, 3);
    check("three_head",  out_data, 1);
    pop_n(3);
    check("drained_valid", out_valid, 1'b0);
    check("drained_data",  out_data,  '0);

    // Fill to full, attempt an extra push, then free one slot.
    push_n(DEPTH);
    check("full_count",    count,       DEPTH);
    check("full_in_ready", in_ready,    1'b0);
    check("full_af",       almost_full, 1'b1);
    step(1'b1, rand_data(), 1'b0, 1'b0, 1'b0);
    check("full_reject", count, DEPTH);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    check("full_pop_ready", in_ready, 1'b1);
    check("full_pop_count", count, DEPTH - 1);

    // Drain to 5, then stream push+pop for 100 cycles.
    pop_n(DEPTH - 1 - 5);
    check("steady_start", count, 5);
    for (int i = 0; i < 100; i++) step(1'b1, rand_data(), 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    check("steady_count", count, 5);
    pop_n(8);

    // Flush with a concurrent push; hwm survives the flush.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("hwm_clr_empty", hwm, 0);
    push_n(20);
    step(1'b1, rand_data(), 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    check("flush_hwm",   hwm, 20);
    check("flush_af",    almost_full, 1'b0);

    // High-water mark clear and regrowth.
    push_n(12);
    pop_n(8);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    hwm_clr = 1'b0;
    check("hwm_after_clr", hwm, 4);
    push_n(2);
    check("hwm_regrow", hwm, 6);

    // Randomised traffic with alternating fill/drain bias, occasional flush and hwm_clr.
    for (int i = 0; i < 1600; i++) begin
      int bias;
      bias = ((i / 200) % 2 == 0) ? 85 : 30;
      step($urandom_range(99) < bias, rand_data(), $urandom_range(99) < (115 - bias),
           $urandom_range(127) == 0, $urandom_range(63) == 0);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    flush = 1'b0;

    // Asynchronous reset mid-stream at count 9.
    push_n(9);
    check("pre_rst_count", count, 9);
    @(negedge clk); #2;
    rstn = 1'b1;
    #1;
    check("arst_count",     count,     0);
    check("arst_hwm",       hwm,       0);
    check("arst_in_ready",  in_ready,  1'b1);
    check("arst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b0;
    step(1'b1, WIDTH'(16'hA5A5), 1'b0, 1'b0, 1'b0);
    step(1'b1, WIDTH'(16'h5A5A), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("post_rst_head", out_data, WIDTH'(16'hA5A5));
    pop_n(2);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
